// File: rtl/sram_responder_if.sv
// sram_responder_if: request/response channel between a load/store requester
// and the data-memory responder.
//   req_valid/req_ready  request handshake
//   req_addr             byte address
//   req_wen              1 = store, 0 = load
//   req_size             0 = byte, 1 = half, 2 = word, 3 = dword
//   req_wdata            store data, right-justified
//   rsp_valid/rsp_ready  response handshake
//   rsp_rdata            load data, right-justified, zero-extended
//   rsp_err              misaligned or out-of-range access
// Modports: master = requester side, slave = responder side.
interface sram_responder_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  req_wen;
  logic [1:0]            req_size;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_addr, req_wen, req_size, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_wen, req_size, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/sram_responder.sv
// sram_responder: target end of the CPU load/store path. Accepts one request
// at a time, waits LATENCY cycles, performs a byte-lane masked store or a
// right-justified zero-extended load, then holds the response until taken.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset (storage array is not reset)
//   bus  sram_responder_if.slave (request and response channels)
module sram_responder #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH = 4096,
  parameter logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(64'h8000_0000),
  parameter int LATENCY = 2
) (
  input logic clk,
  input logic rst,
  sram_responder_if.slave bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(DEPTH) << 3;
  localparam bit ZERO_LAT = (LATENCY == 0);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  // Byte enables for an access of 2^size bytes starting at lane.
  function automatic logic [7:0] laneMask(input logic [1:0] size, input logic [2:0] lane);
    logic [7:0] m;
    case (size)
      2'd0:    m = 8'h01;
      2'd1:    m = 8'h03;
      2'd2:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m << lane;
  endfunction

  // Keeps the low 2^size bytes of a right-justified load.
  function automatic logic [DATA_WIDTH-1:0] sizeMask(input logic [1:0] size);
    logic [DATA_WIDTH-1:0] m;
    case (size)
      2'd0:    m = DATA_WIDTH'(64'h0000_0000_0000_00FF);
      2'd1:    m = DATA_WIDTH'(64'h0000_0000_0000_FFFF);
      2'd2:    m = DATA_WIDTH'(64'h0000_0000_FFFF_FFFF);
      default: m = DATA_WIDTH'(64'hFFFF_FFFF_FFFF_FFFF);
    endcase
    return m;
  endfunction

  function automatic logic misaligned(input logic [2:0] lane, input logic [1:0] size);
    logic r;
    case (size)
      2'd0:    r = 1'b0;
      2'd1:    r = lane[0];
      2'd2:    r = |lane[1:0];
      default: r = |lane;
    endcase
    return r;
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_t                stateQ;
  logic [3:0]            cntQ;
  logic                  reqReadyQ;
  logic                  rspValidQ;
  logic [DATA_WIDTH-1:0] rspRdataQ;
  logic                  rspErrQ;

  logic [ADDR_WIDTH-1:0] addrQ;
  logic                  wenQ;
  logic [1:0]            sizeQ;
  logic [DATA_WIDTH-1:0] wdataQ;

  logic [ADDR_WIDTH-1:0] accAddr;
  logic                  accWen;
  logic [1:0]            accSize;
  logic [DATA_WIDTH-1:0] accWdata;
  logic [ADDR_WIDTH-1:0] accOff;
  logic [2:0]            accLane;
  logic [IDX_W-1:0]      accIdx;
  logic                  accErr;
  logic [7:0]            accMask;
  logic [DATA_WIDTH-1:0] accWbytes;
  logic [DATA_WIDTH-1:0] accRdata;
  logic                  doAccess;
  logic                  doWrite;

  // With zero latency the access happens on the accept edge, so it must use
  // the live request rather than the latched copy.
  assign accAddr  = ZERO_LAT ? bus.req_addr  : addrQ;
  assign accWen   = ZERO_LAT ? bus.req_wen   : wenQ;
  assign accSize  = ZERO_LAT ? bus.req_size  : sizeQ;
  assign accWdata = ZERO_LAT ? bus.req_wdata : wdataQ;

  // Addresses below BASE wrap to a huge offset and fall out of range.
  always_comb begin
    accOff    = accAddr - BASE;
    accLane   = accAddr[2:0];
    accIdx    = accOff[IDX_W+2:3];
    accErr    = (accOff >= SPAN) || misaligned(accLane, accSize);
    accMask   = laneMask(accSize, accLane);
    accWbytes = accWdata << {accLane, 3'b000};
    accRdata  = '0;
    if (!accErr && !accWen) begin
      accRdata = (mem[accIdx] >> {accLane, 3'b000}) & sizeMask(accSize);
    end
  end

  // Gated by rst so a request aborted by reset never commits a store.
  assign doAccess = !rst && ((stateQ == WAIT && cntQ == 4'd1) ||
                             (ZERO_LAT && stateQ == IDLE && bus.req_valid));
  assign doWrite  = doAccess && accWen && !accErr;

  // Storage
  always_ff @(posedge clk) begin
    if (doWrite) begin
      for (int b = 0; b < 8; b++) begin
        if (accMask[b]) mem[accIdx][8*b +: 8] <= accWbytes[8*b +: 8];
      end
    end
  end

  // Request capture
  always_ff @(posedge clk) begin
    if (stateQ == IDLE && bus.req_valid) begin
      addrQ  <= bus.req_addr;
      wenQ   <= bus.req_wen;
      sizeQ  <= bus.req_size;
      wdataQ <= bus.req_wdata;
    end
  end

  // Control FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ    <= IDLE;
      cntQ      <= '0;
      reqReadyQ <= 1'b1;
      rspValidQ <= 1'b0;
      rspRdataQ <= '0;
      rspErrQ   <= 1'b0;
    end else begin
      case (stateQ)
        IDLE: begin
          if (bus.req_valid) begin
            reqReadyQ <= 1'b0;
            if (ZERO_LAT) begin
              stateQ    <= RESP;
              rspValidQ <= 1'b1;
              rspRdataQ <= accRdata;
              rspErrQ   <= accErr;
            end else begin
              stateQ <= WAIT;
              cntQ   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          cntQ <= cntQ - 4'd1;
          if (cntQ == 4'd1) begin
            stateQ    <= RESP;
            rspValidQ <= 1'b1;
            rspRdataQ <= accRdata;
            rspErrQ   <= accErr;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            stateQ    <= IDLE;
            rspValidQ <= 1'b0;
            reqReadyQ <= 1'b1;
          end
        end
        default: begin
          stateQ    <= IDLE;
          reqReadyQ <= 1'b1;
          rspValidQ <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = reqReadyQ;
  assign bus.rsp_valid = rspValidQ;
  assign bus.rsp_rdata = rspRdataQ;
  assign bus.rsp_err   = rspErrQ;

endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: drives a LATENCY=2 responder (index 0) and a LATENCY=0
// responder (index 1). A byte-addressed reference memory predicts every
// response; literal expectations pin the headline cases.
module tb_sram_responder;

  localparam logic [63:0] BASE  = 64'h8000_0000;
  localparam int          DEPTH = 4096;
  localparam int          LAT [2] = '{2, 0};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        reqValid [2];
  logic        reqWen   [2];
  logic [1:0]  reqSize  [2];
  logic [63:0] reqAddr  [2];
  logic [63:0] reqWdata [2];
  logic        rspReady [2];
  logic        reqReady [2];
  logic        rspValid [2];
  logic        rspErr   [2];
  logic [63:0] rspRdata [2];

  sram_responder_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) busA ();
  sram_responder_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) busB ();

  assign busA.req_valid = reqValid[0];
  assign busA.req_wen   = reqWen[0];
  assign busA.req_size  = reqSize[0];
  assign busA.req_addr  = reqAddr[0];
  assign busA.req_wdata = reqWdata[0];
  assign busA.rsp_ready = rspReady[0];
  assign reqReady[0]    = busA.req_ready;
  assign rspValid[0]    = busA.rsp_valid;
  assign rspErr[0]      = busA.rsp_err;
  assign rspRdata[0]    = busA.rsp_rdata;

  assign busB.req_valid = reqValid[1];
  assign busB.req_wen   = reqWen[1];
  assign busB.req_size  = reqSize[1];
  assign busB.req_addr  = reqAddr[1];
  assign busB.req_wdata = reqWdata[1];
  assign busB.rsp_ready = rspReady[1];
  assign reqReady[1]    = busB.req_ready;
  assign rspValid[1]    = busB.rsp_valid;
  assign rspErr[1]      = busB.rsp_err;
  assign rspRdata[1]    = busB.rsp_rdata;

  sram_responder #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .DEPTH(DEPTH), .BASE(BASE), .LATENCY(2))
    dutA (.clk(clk), .rst(rst), .bus(busA.slave));
  sram_responder #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .DEPTH(DEPTH), .BASE(BASE), .LATENCY(0))
    dutB (.clk(clk), .rst(rst), .bus(busB.slave));

  int nChecks = 0;
  int nPass   = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, got, exp, $time);
  endtask

  // Reference memory: one entry per written byte address.
  logic [7:0] memA [logic [63:0]];
  logic [7:0] memB [logic [63:0]];

  function automatic logic [7:0] byteOf(input int d, input logic [63:0] a);
    if (d == 0) return memA.exists(a) ? memA[a] : 8'h00;
    return memB.exists(a) ? memB[a] : 8'h00;
  endfunction

  task automatic modelAccess(input int d, input logic [63:0] a, input logic w,
                             input logic [1:0] s, input logic [63:0] wd,
                             output logic [63:0] rd, output logic er);
    int nb;
    logic [63:0] off;
    nb  = 1 << s;
    off = a - BASE;
    er  = (off >= 64'(DEPTH) * 64'd8) || ((a % 64'(nb)) != 64'd0);
    rd  = '0;
    if (!er) begin
      for (int i = 0; i < nb; i++) begin
        if (w) begin
          if (d == 0) memA[a + 64'(i)] = wd[8*i +: 8];
          else        memB[a + 64'(i)] = wd[8*i +: 8];
        end else begin
          rd = rd | (64'(byteOf(d, a + 64'(i))) << (8*i));
        end
      end
    end
  endtask

  // Compare process: a request accepted at edge k must show its response in
  // the cycle after edge k+LAT and hold it until rsp_ready is seen.
  int          cycN = 0;
  bit          pend [2] = '{0, 0};
  int          due  [2];
  logic [63:0] pA [2], pD [2];
  logic        pW [2];
  logic [1:0]  pS [2];
  logic [63:0] eRd [2];
  logic        eEr [2];

  always @(negedge clk) begin
    cycN++;
    for (int d = 0; d < 2; d++) begin
      bit ev;
      if (rst) begin
        pend[d] = 0;
        chk("rst_req_ready", 64'(reqReady[d]), 64'd1);
        chk("rst_rsp_valid", 64'(rspValid[d]), 64'd0);
        chk("rst_rsp_rdata", rspRdata[d], 64'd0);
        chk("rst_rsp_err",   64'(rspErr[d]), 64'd0);
      end else begin
        if (pend[d] && cycN == due[d])
          modelAccess(d, pA[d], pW[d], pS[d], pD[d], eRd[d], eEr[d]);
        ev = pend[d] && (cycN >= due[d]);
        chk("mon_req_ready", 64'(reqReady[d]), 64'(!pend[d]));
        chk("mon_rsp_valid", 64'(rspValid[d]), 64'(ev));
        if (ev) begin
          chk("mon_rsp_rdata", rspRdata[d], eRd[d]);
          chk("mon_rsp_err",   64'(rspErr[d]), 64'(eEr[d]));
        end
        if (ev && rspReady[d]) begin
          pend[d] = 0;
        end else if (!pend[d] && reqValid[d]) begin
          pend[d] = 1;
          pA[d] = reqAddr[d];
          pW[d] = reqWen[d];
          pS[d] = reqSize[d];
          pD[d] = reqWdata[d];
          due[d] = cycN + 1 + LAT[d];
        end
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // One full transaction; hold > 0 keeps rsp_ready low for hold cycles.
  task automatic xact(input int d, input logic [63:0] a, input logic w, input logic [1:0] s,
                      input logic [63:0] wd, input int hold,
                      output logic [63:0] rd, output logic er, output int lat);
    int n;
    reqAddr[d] = a; reqWen[d] = w; reqSize[d] = s; reqWdata[d] = wd;
    reqValid[d] = 1'b1;
    rspReady[d] = (hold == 0);
    n = 0;
    @(negedge clk);
    while (!reqReady[d] && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!reqReady[d]) chk("accept_timeout", 64'(reqReady[d]), 64'd1);
    @(posedge clk);
    #1;
    reqValid[d] = 1'b0;
    reqAddr[d]  = '1;
    reqWdata[d] = '1;
    reqSize[d]  = 2'd0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rspValid[d] && lat < 40);
    if (!rspValid[d]) chk("response_timeout", 64'(rspValid[d]), 64'd1);
    rd = rspRdata[d];
    er = rspErr[d];
    if (hold > 0) begin
      for (int i = 1; i < hold; i++) begin
        @(negedge clk);
        chk("bp_rsp_valid", 64'(rspValid[d]), 64'd1);
        chk("bp_rsp_rdata", rspRdata[d], rd);
        chk("bp_req_ready", 64'(reqReady[d]), 64'd0);
      end
      @(posedge clk);
      #1;
      rspReady[d] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  logic [63:0] rd;
  logic        er;
  int          lat;
  int          n;
  int          accCyc [4];
  logic [63:0] bA [4] = '{64'h8000_0100, 64'h8000_0100, 64'h8000_0106, 64'h8000_0100};
  logic        bW [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic [1:0]  bS [4] = '{2'd3, 2'd3, 2'd1, 2'd3};
  logic [63:0] bD [4] = '{64'hCAFE_F00D_DEAD_BEEF, 64'd0, 64'h0000_0000_0000_1234, 64'd0};

  initial begin
    for (int d = 0; d < 2; d++) begin
      reqValid[d] = 1'b0; reqWen[d] = 1'b0; reqSize[d] = 2'd0;
      reqAddr[d] = '0; reqWdata[d] = '0; rspReady[d] = 1'b1;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_req_ready", 64'(reqReady[0]), 64'd1);
    chk("reset_rsp_valid", 64'(rspValid[0]), 64'd0);
    chk("reset_rsp_rdata", rspRdata[0], 64'd0);
    chk("reset_rsp_err",   64'(rspErr[0]), 64'd0);
    @(posedge clk);
    #1;

    // Dword store then load
    xact(0, 64'h8000_0010, 1'b1, 2'd3, 64'h1122_3344_5566_7788, 0, rd, er, lat);
    chk("t1_store_err", 64'(er), 64'd0);
    chk("t1_store_rdata", rd, 64'd0);
    chk("t1_store_latency", 64'(lat), 64'd3);
    xact(0, 64'h8000_0010, 1'b0, 2'd3, 64'd0, 0, rd, er, lat);
    chk("t1_load_dword", rd, 64'h1122_3344_5566_7788);

    // Byte store only touches its own lane
    xact(0, 64'h8000_0013, 1'b1, 2'd0, 64'hFFFF_FFFF_FFFF_FFAB, 0, rd, er, lat);
    chk("t2_store_err", 64'(er), 64'd0);
    xact(0, 64'h8000_0010, 1'b0, 2'd3, 64'd0, 0, rd, er, lat);
    chk("t2_load_dword", rd, 64'h1122_3344_AB66_7788);
    xact(0, 64'h8000_0012, 1'b0, 2'd1, 64'd0, 0, rd, er, lat);
    chk("t2_load_half", rd, 64'h0000_0000_0000_AB66);

    // Errors: misaligned, past the end, below BASE
    xact(0, 64'h8000_0012, 1'b0, 2'd2, 64'd0, 0, rd, er, lat);
    chk("t3_misal_err", 64'(er), 64'd1);
    chk("t3_misal_rdata", rd, 64'd0);
    xact(0, 64'h8000_0012, 1'b1, 2'd2, 64'hDEAD_BEEF, 0, rd, er, lat);
    chk("t3_misal_store_err", 64'(er), 64'd1);
    xact(0, BASE + 64'(DEPTH) * 8, 1'b0, 2'd3, 64'd0, 0, rd, er, lat);
    chk("t3_oor_err", 64'(er), 64'd1);
    chk("t3_oor_rdata", rd, 64'd0);
    xact(0, BASE + 64'(DEPTH) * 8, 1'b1, 2'd3, 64'h5555_5555_5555_5555, 0, rd, er, lat);
    chk("t3_oor_store_err", 64'(er), 64'd1);
    xact(0, 64'h7FFF_FFF8, 1'b0, 2'd3, 64'd0, 0, rd, er, lat);
    chk("t3_below_base_err", 64'(er), 64'd1);
    xact(0, 64'h8000_0010, 1'b0, 2'd3, 64'd0, 0, rd, er, lat);
    chk("t3_mem_unchanged", rd, 64'h1122_3344_AB66_7788);
    xact(0, BASE + 64'(DEPTH) * 8 - 8, 1'b1, 2'd3, 64'h0123_4567_89AB_CDEF, 0, rd, er, lat);
    chk("t3_last_store_err", 64'(er), 64'd0);
    xact(0, BASE + 64'(DEPTH) * 8 - 8, 1'b0, 2'd3, 64'd0, 0, rd, er, lat);
    chk("t3_last_load", rd, 64'h0123_4567_89AB_CDEF);

    // Backpressure for 5 cycles
    xact(0, 64'h8000_0010, 1'b0, 2'd3, 64'd0, 5, rd, er, lat);
    chk("t4_bp_rdata", rd, 64'h1122_3344_AB66_7788);
    @(negedge clk);
    chk("t4_idle_req_ready", 64'(reqReady[0]), 64'd1);
    chk("t4_idle_rsp_valid", 64'(rspValid[0]), 64'd0);
    @(posedge clk);
    #1;

    // Reset during WAIT aborts a store
    xact(0, 64'h8000_0020, 1'b1, 2'd3, 64'h0102_0304_0506_0708, 0, rd, er, lat);
    xact(0, 64'h8000_0020, 1'b0, 2'd3, 64'd0, 0, rd, er, lat);
    chk("t6_pre_load", rd, 64'h0102_0304_0506_0708);
    reqAddr[0] = 64'h8000_0020; reqWen[0] = 1'b1; reqSize[0] = 2'd0;
    reqWdata[0] = 64'hFF; reqValid[0] = 1'b1; rspReady[0] = 1'b1;
    @(negedge clk);
    chk("t6_ready_before_abort", 64'(reqReady[0]), 64'd1);
    @(posedge clk);
    #1;
    reqValid[0] = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("t6_abort_req_ready", 64'(reqReady[0]), 64'd1);
    chk("t6_abort_rsp_valid", 64'(rspValid[0]), 64'd0);
    chk("t6_abort_rsp_rdata", rspRdata[0], 64'd0);
    chk("t6_abort_rsp_err",   64'(rspErr[0]), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    xact(0, 64'h8000_0020, 1'b0, 2'd3, 64'd0, 0, rd, er, lat);
    chk("t6_old_data", rd, 64'h0102_0304_0506_0708);

    // Zero-latency instance, req_valid held high across requests
    reqAddr[1] = bA[0]; reqWen[1] = bW[0]; reqSize[1] = bS[0]; reqWdata[1] = bD[0];
    reqValid[1] = 1'b1; rspReady[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      @(negedge clk);
      while (!reqReady[1] && n < 10) begin
        @(negedge clk);
        n++;
      end
      accCyc[i] = cyc;
      @(posedge clk);
      #1;
      if (i < 3) begin
        reqAddr[1] = bA[i+1]; reqWen[1] = bW[i+1]; reqSize[1] = bS[i+1]; reqWdata[1] = bD[i+1];
      end else begin
        reqValid[1] = 1'b0;
      end
      @(negedge clk);
      chk("t5_rsp_next_cycle", 64'(rspValid[1]), 64'd1);
      if (i == 1) chk("t5_load_dword", rspRdata[1], 64'hCAFE_F00D_DEAD_BEEF);
      if (i == 3) chk("t5_load_after_half", rspRdata[1], 64'h1234_F00D_DEAD_BEEF);
      if (i > 0) chk("t5_accept_spacing", 64'(accCyc[i] - accCyc[i-1]), 64'd2);
    end
    @(posedge clk);
    #1;
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not complete, %0d/%0d so far", nPass, nChecks);
    $fatal(1, "timeout");
  end

endmodule
